// File: rtl/voice_bus_regs.sv
// Per-voice register file: syncs BusClock into Clock, commits byte writes as 24-bit parameters, gate-edge strobes.
// Optional combinational readback onto BusData when VOICE_REGS_READBACK_EN is defined; otherwise BusData is never driven.
module voice_bus_regs #(
    parameter logic [15:0] BASE_ADDR = 16'h0010
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] BusAddress,
    inout  wire  [7:0]  BusData,
    input  logic        BusReadWrite,
    input  logic        BusClock,
    output logic        Gate,
    output logic        GateRise,
    output logic        GateFall,
    output logic [23:0] Incr,
    output logic [1:0]  WaveType,
    output logic [23:0] PulseWidth,
    output logic [23:0] Attack,
    output logic [23:0] Decay,
    output logic [23:0] Sustain,
    output logic [23:0] Release,
    output logic        Linear
);

    // Synchroniser flops reset high so a BusClock already high out of reset is not an edge.
    logic s1_q, s2_q, s3_q;
    logic wr_stb;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= BusClock;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign wr_stb = s2_q & ~s3_q & BusReadWrite;

    logic [15:0] offset;
    logic        in_win;
    logic [4:0]  off;

    assign offset = BusAddress - BASE_ADDR;
    assign in_win = (offset[15:5] == 11'd0);
    assign off    = offset[4:0];

    // Decode: p_sel picks one of the six 24-bit parameters, p_byte the byte lane.
    logic [2:0] p_sel;
    logic [1:0] p_byte;
    logic       p_hit, g_hit, w_hit, l_hit;

    always_comb begin
        p_sel  = 3'd0;
        p_byte = 2'd0;
        p_hit  = 1'b0;
        g_hit  = 1'b0;
        w_hit  = 1'b0;
        l_hit  = 1'b0;
        case (off)
            5'h00:                      g_hit = 1'b1;
            5'h01, 5'h02, 5'h03: begin p_hit = 1'b1; p_sel = 3'd0; p_byte = 2'(off - 5'h01); end
            5'h04:                      w_hit = 1'b1;
            5'h05, 5'h06, 5'h07: begin p_hit = 1'b1; p_sel = 3'd1; p_byte = 2'(off - 5'h05); end
            5'h08, 5'h09, 5'h0A: begin p_hit = 1'b1; p_sel = 3'd2; p_byte = 2'(off - 5'h08); end
            5'h0B, 5'h0C, 5'h0D: begin p_hit = 1'b1; p_sel = 3'd3; p_byte = 2'(off - 5'h0B); end
            5'h0E, 5'h0F, 5'h10: begin p_hit = 1'b1; p_sel = 3'd4; p_byte = 2'(off - 5'h0E); end
            5'h11, 5'h12, 5'h13: begin p_hit = 1'b1; p_sel = 3'd5; p_byte = 2'(off - 5'h11); end
            5'h14:                      l_hit = 1'b1;
            default: ;
        endcase
    end

    logic do_wr;
    assign do_wr = wr_stb & in_win;

    logic [7:0]  sh0_q [6];
    logic [7:0]  sh1_q [6];
    logic [23:0] par_q [6];

    // High byte commits the full word at once, reusing whatever the shadows hold.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 6; i++) begin
                sh0_q[i] <= 8'h00;
                sh1_q[i] <= 8'h00;
                par_q[i] <= 24'h000000;
            end
        end else if (do_wr && p_hit) begin
            case (p_byte)
                2'd0:    sh0_q[p_sel] <= BusData;
                2'd1:    sh1_q[p_sel] <= BusData;
                2'd2:    par_q[p_sel] <= {BusData, sh1_q[p_sel], sh0_q[p_sel]};
                default: ;
            endcase
        end
    end

    logic       gate_q, gate_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;
    logic [1:0] wave_q, wave_d;
    logic       lin_q,  lin_d;

    always_comb begin
        gate_d = (do_wr && g_hit) ? BusData[0]   : gate_q;
        wave_d = (do_wr && w_hit) ? BusData[1:0] : wave_q;
        lin_d  = (do_wr && l_hit) ? BusData[0]   : lin_q;
        rise_d = gate_d & ~gate_q;
        fall_d = ~gate_d & gate_q;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            gate_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            wave_q <= 2'd0;
            lin_q  <= 1'b0;
        end else begin
            gate_q <= gate_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            wave_q <= wave_d;
            lin_q  <= lin_d;
        end
    end

    assign Gate       = gate_q;
    assign GateRise   = rise_q;
    assign GateFall   = fall_q;
    assign WaveType   = wave_q;
    assign Linear     = lin_q;
    assign Incr       = par_q[0];
    assign PulseWidth = par_q[1];
    assign Attack     = par_q[2];
    assign Decay      = par_q[3];
    assign Sustain    = par_q[4];
    assign Release    = par_q[5];

`ifdef VOICE_REGS_READBACK_EN
    // Readback returns committed words, never the shadows.
    logic [7:0] rd_byte;

    always_comb begin
        rd_byte = 8'h00;
        if (p_hit) begin
            case (p_byte)
                2'd0:    rd_byte = par_q[p_sel][7:0];
                2'd1:    rd_byte = par_q[p_sel][15:8];
                2'd2:    rd_byte = par_q[p_sel][23:16];
                default: rd_byte = 8'h00;
            endcase
        end else if (g_hit) begin
            rd_byte = {7'd0, gate_q};
        end else if (w_hit) begin
            rd_byte = {6'd0, wave_q};
        end else if (l_hit) begin
            rd_byte = {7'd0, lin_q};
        end
    end

    assign BusData = (!BusReadWrite && in_win) ? rd_byte : 8'hzz;
`endif

endmodule
